// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues single-outstanding AXI-lite reads
// to the instruction SRAM and presents each instruction to decode via valid/ready.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_err_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        err_q, err_d;
    logic        pc_misaligned_s;
    logic        ar_fire_s;

    assign pc_misaligned_s = (pc_q[1:0] != 2'b00);
    assign arvalid         = (state_q == ADDR) && !pc_misaligned_s;
    assign ar_fire_s       = arvalid && arready;
    assign araddr          = pc_q;
    assign rready          = (state_q == DATA);
    assign inst_valid_o    = (state_q == HOLD);
    assign inst_o          = inst_q;
    assign pc_o            = pc_out_q;
    assign inst_err_o      = err_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            kill_q   <= 1'b0;
            inst_q   <= INST_NOP;
            pc_out_q <= RESET_PC;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        kill_d   = kill_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                state_d = ADDR;
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_i;
                end else begin
                    pc_d = pc_q;
                end
            end

            ADDR: begin
                if (ar_fire_s) begin
                    state_d = DATA;
                    if (redirect_valid_i) begin
                        // The in-flight read now targets a stale PC
                        pc_d   = redirect_pc_i;
                        kill_d = 1'b1;
                    end else begin
                        kill_d = 1'b0;
                    end
                end else if (redirect_valid_i) begin
                    pc_d = redirect_pc_i;
                end else if (pc_misaligned_s) begin
                    state_d  = HOLD;
                    inst_d   = INST_NOP;
                    pc_out_d = pc_q;
                    err_d    = 1'b1;
                end else begin
                    state_d = ADDR;
                end
            end

            DATA: begin
                if (rvalid) begin
                    if (kill_q || redirect_valid_i) begin
                        state_d = ADDR;
                        kill_d  = 1'b0;
                        if (redirect_valid_i) begin
                            pc_d = redirect_pc_i;
                        end else begin
                            pc_d = pc_q;
                        end
                    end else begin
                        state_d  = HOLD;
                        inst_d   = rdata;
                        pc_out_d = pc_q;
                        err_d    = (rresp != 2'b00);
                    end
                end else if (redirect_valid_i) begin
                    pc_d   = redirect_pc_i;
                    kill_d = 1'b1;
                end else begin
                    state_d = DATA;
                end
            end

            HOLD: begin
                if (redirect_valid_i) begin
                    // Redirect target wins over pc+4 even if decode consumes now
                    state_d = ADDR;
                    pc_d    = redirect_pc_i;
                    inst_d  = INST_NOP;
                end else if (inst_ready_i) begin
                    state_d = ADDR;
                    pc_d    = pc_q + 32'd4;
                    inst_d  = INST_NOP;
                end else begin
                    state_d = HOLD;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch; drives a hand-scripted SRAM slave
// and checks outputs 1 ns after each rising edge against hand-computed values.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_err_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;

    int n_cmp;
    int n_err;

    ifu_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .araddr           (araddr),
        .arvalid          (arvalid),
        .arready          (arready),
        .rdata            (rdata),
        .rresp            (rresp),
        .rvalid           (rvalid),
        .rready           (rready),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .inst_err_o       (inst_err_o),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arvalid"}, {31'd0, arvalid}, 32'd0);
        chk({tag, "_rready"},  {31'd0, rready}, 32'd0);
        chk({tag, "_valid"},   {31'd0, inst_valid_o}, 32'd0);
        chk({tag, "_inst"},    inst_o, 32'h0000_0013);
        chk({tag, "_pc"},      pc_o, 32'h8000_0000);
        chk({tag, "_err"},     {31'd0, inst_err_o}, 32'd0);
        chk({tag, "_araddr"},  araddr, 32'h8000_0000);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        arready = 1'b0;
        rdata = 32'd0;
        rresp = 2'b00;
        rvalid = 1'b0;
        inst_ready_i = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i = 32'd0;

        tick();
        tick();
        chk_reset_outputs("reset");

        // Reset release and first fetch, zero wait states
        rst = 1'b0;
        chk("idle_arvalid", {31'd0, arvalid}, 32'd0);
        tick();
        chk("first_arvalid", {31'd0, arvalid}, 32'd1);
        chk("first_araddr", araddr, 32'h8000_0000);
        arready = 1'b1;
        tick();
        chk("data_rready", {31'd0, rready}, 32'd1);
        chk("data_arvalid", {31'd0, arvalid}, 32'd0);
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h0010_0093;
        tick();
        rvalid = 1'b0;
        chk("first_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("first_inst", inst_o, 32'h0010_0093);
        chk("first_pc", pc_o, 32'h8000_0000);
        chk("first_err", {31'd0, inst_err_o}, 32'd0);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk("next_araddr", araddr, 32'h8000_0004);
        chk("next_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("next_inst_nop", inst_o, 32'h0000_0013);

        // Decode back-pressure
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 32'hAAAA_0001;
        tick();
        rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, inst_valid_o}, 32'd1);
            chk("bp_inst", inst_o, 32'hAAAA_0001);
            chk("bp_pc", pc_o, 32'h8000_0004);
            chk("bp_no_ar", {31'd0, arvalid}, 32'd0);
            tick();
        end
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk("bp_next_araddr", araddr, 32'h8000_0008);
        chk("bp_next_arvalid", {31'd0, arvalid}, 32'd1);

        // Redirect while in DATA; late rvalid must be discarded
        arready = 1'b1;
        tick();
        arready = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h8000_0100;
        tick();
        redirect_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("kill_wait_valid", {31'd0, inst_valid_o}, 32'd0);
            chk("kill_wait_rready", {31'd0, rready}, 32'd1);
            tick();
        end
        rvalid = 1'b1;
        rdata = 32'hDEAD_BEEF;
        tick();
        rvalid = 1'b0;
        chk("kill_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("kill_inst", inst_o, 32'h0000_0013);
        chk("kill_arvalid", {31'd0, arvalid}, 32'd1);
        chk("kill_araddr", araddr, 32'h8000_0100);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h1111_1111;
        tick();
        rvalid = 1'b0;
        chk("redir_inst", inst_o, 32'h1111_1111);
        chk("redir_pc", pc_o, 32'h8000_0100);

        // Redirect in HOLD simultaneous with handshake
        inst_ready_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h8000_0200;
        tick();
        inst_ready_i = 1'b0;
        redirect_valid_i = 1'b0;
        chk("hold_redir_araddr", araddr, 32'h8000_0200);
        chk("hold_redir_valid", {31'd0, inst_valid_o}, 32'd0);

        // Error response
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 32'hCAFE_F00D;
        rresp = 2'b10;
        tick();
        rvalid = 1'b0;
        rresp = 2'b00;
        chk("rresp_err", {31'd0, inst_err_o}, 32'd1);
        chk("rresp_inst", inst_o, 32'hCAFE_F00D);
        chk("rresp_pc", pc_o, 32'h8000_0200);

        // Redirect to a misaligned PC: no AR, NOP with error
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h8000_0002;
        tick();
        redirect_valid_i = 1'b0;
        arready = 1'b1;
        chk("mis_arvalid", {31'd0, arvalid}, 32'd0);
        chk("mis_araddr", araddr, 32'h8000_0002);
        tick();
        chk("mis_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("mis_inst", inst_o, 32'h0000_0013);
        chk("mis_err", {31'd0, inst_err_o}, 32'd1);
        chk("mis_pc", pc_o, 32'h8000_0002);
        chk("mis_hold_arvalid", {31'd0, arvalid}, 32'd0);
        arready = 1'b0;
        inst_ready_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h8000_0300;
        tick();
        inst_ready_i = 1'b0;
        redirect_valid_i = 1'b0;
        chk("mis_exit_araddr", araddr, 32'h8000_0300);

        // Reset asserted mid-DATA with rvalid pending
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rstdata_rready", {31'd0, rready}, 32'd1);
        rst = 1'b1;
        rvalid = 1'b1;
        rdata = 32'hBADB_AD00;
        tick();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        rvalid = 1'b0;
        chk("postrst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("postrst_arvalid", {31'd0, arvalid}, 32'd1);
        chk("postrst_araddr", araddr, 32'h8000_0000);
        chk("postrst_inst", inst_o, 32'h0000_0013);

        // Redirect in ADDR without accept, then PC wrap on handshake
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_valid_i = 1'b0;
        chk("wrap_araddr", araddr, 32'hFFFF_FFFC);
        chk("wrap_arvalid", {31'd0, arvalid}, 32'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h1234_5678;
        tick();
        rvalid = 1'b0;
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap_inst", inst_o, 32'h1234_5678);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk("wrap_next_araddr", araddr, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
